// File: rtl/id_ex_stage_if.sv
// ---------------------------------------------------------------------------
// id_ex_stage_if
//
// Purpose:
//    Bundles every non-clock signal of the ID/EX pipeline register into one
//    interface. The stage itself connects through the 'slave' modport. The
//    surrounding pipeline (decode, EX/MEM and MEM/WB latches, the ALU) or a
//    testbench connects through the 'master' modport.
//
// Signal summary (directions as seen by the stage / slave side):
//    Control
//       flush                 in   squash the held entry (branch/jump redirect)
//    Decode handshake
//       in_valid              in   decode presents an instruction
//       in_ready              out  stage can accept an instruction this cycle
//    Decoded instruction fields
//       in_aluop[3:0]         in   ALU opcode
//       in_rs, in_rt          in   source register indices
//       in_rdat1, in_rdat2    in   register file read data
//       in_imm16              in   16-bit immediate
//       in_shamt              in   shift amount
//       in_alusrc[1:0]        in   B select: 0 reg, 1 ext imm, 2 shamt, 3 lui
//       in_extop              in   1 = sign-extend imm16, 0 = zero-extend
//       in_memwen             in   store instruction
//       in_memren             in   load instruction
//       in_regwen             in   instruction writes a register
//       in_wsel               in   destination register index
//    Forwarding sources
//       exm_regwen, exm_memren, exm_wsel, exm_wdat    in  EX/MEM latch
//       mwb_regwen, mwb_wsel, mwb_wdat                in  MEM/WB latch
//    ALU handshake and operands
//       out_valid             out  A/B/ALUOP are valid for the ALU
//       out_ready             in   downstream accepts this cycle
//       A, B                  out  ALU operands
//       ALUOP[3:0]            out  ALU opcode
//       out_stdat             out  forwarded rt value (store data)
//       out_memwen, out_memren, out_regwen, out_wsel   out  registered controls
// ---------------------------------------------------------------------------
interface id_ex_stage_if #(
   parameter int WORD_W = 32,
   parameter int REG_W  = 5
);

   logic              flush;

   logic              in_valid;
   logic              in_ready;
   logic [3:0]        in_aluop;
   logic [REG_W-1:0]  in_rs;
   logic [REG_W-1:0]  in_rt;
   logic [WORD_W-1:0] in_rdat1;
   logic [WORD_W-1:0] in_rdat2;
   logic [15:0]       in_imm16;
   logic [4:0]        in_shamt;
   logic [1:0]        in_alusrc;
   logic              in_extop;
   logic              in_memwen;
   logic              in_memren;
   logic              in_regwen;
   logic [REG_W-1:0]  in_wsel;

   logic              exm_regwen;
   logic              exm_memren;
   logic [REG_W-1:0]  exm_wsel;
   logic [WORD_W-1:0] exm_wdat;

   logic              mwb_regwen;
   logic [REG_W-1:0]  mwb_wsel;
   logic [WORD_W-1:0] mwb_wdat;

   logic              out_valid;
   logic              out_ready;
   logic [WORD_W-1:0] A;
   logic [WORD_W-1:0] B;
   logic [3:0]        ALUOP;
   logic [WORD_W-1:0] out_stdat;
   logic              out_memwen;
   logic              out_memren;
   logic              out_regwen;
   logic [REG_W-1:0]  out_wsel;

   // The pipeline stage itself
   modport slave (
      input  flush,
      input  in_valid,
      output in_ready,
      input  in_aluop, in_rs, in_rt, in_rdat1, in_rdat2, in_imm16, in_shamt,
      input  in_alusrc, in_extop, in_memwen, in_memren, in_regwen, in_wsel,
      input  exm_regwen, exm_memren, exm_wsel, exm_wdat,
      input  mwb_regwen, mwb_wsel, mwb_wdat,
      output out_valid,
      input  out_ready,
      output A, B, ALUOP, out_stdat,
      output out_memwen, out_memren, out_regwen, out_wsel
   );

   // The environment around the stage (decode, later stages, ALU)
   modport master (
      output flush,
      output in_valid,
      input  in_ready,
      output in_aluop, in_rs, in_rt, in_rdat1, in_rdat2, in_imm16, in_shamt,
      output in_alusrc, in_extop, in_memwen, in_memren, in_regwen, in_wsel,
      output exm_regwen, exm_memren, exm_wsel, exm_wdat,
      output mwb_regwen, mwb_wsel, mwb_wdat,
      input  out_valid,
      output out_ready,
      input  A, B, ALUOP, out_stdat,
      input  out_memwen, out_memren, out_regwen, out_wsel
   );

endinterface

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//
// Purpose:
//    ID/EX pipeline register sitting directly in front of the ALU. It holds
//    one decoded instruction and applies EX/MEM and MEM/WB forwarding to the
//    held source operands. It then builds the ALU A/B operands (register,
//    extended immediate, shift amount or LUI) and stalls on a load-use
//    hazard. Both sides use a valid/ready handshake. A held entry can retire
//    and a new one be captured in the same cycle, so throughput is one
//    instruction per cycle.
//
// Ports:
//    CLK        in   clock
//    nRST       in   asynchronous active-low reset
//    bus        id_ex_stage_if.slave (decode handshake, forwarding sources,
//               ALU operands/handshake, registered controls)
//    stall_cnt  out  [STALL_CNT_W] saturating count of cycles in which a held
//               entry could not leave. Present only when the macro
//               ID_EX_STALL_CNT_EN is defined.
//
// Configuration:
//    ID_EX_STALL_CNT_EN - when defined, adds the stall_cnt output, its
//    counter and the STALL_CNT_W parameter. When undefined, the stage has no
//    counter and behaves identically otherwise.
// ---------------------------------------------------------------------------
module id_ex_stage #(
   parameter int WORD_W      = 32,
   parameter int REG_W       = 5
`ifdef ID_EX_STALL_CNT_EN
   ,
   parameter int STALL_CNT_W = 16
`endif
) (
   input  logic                   CLK,
   input  logic                   nRST,
   id_ex_stage_if.slave           bus
`ifdef ID_EX_STALL_CNT_EN
   ,
   output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

   // ALU opcode that the ALUOP register returns to on reset
   localparam logic [3:0] ALU_SLL = 4'd0;

   // Sources for the ALU B operand (A follows from the same choice)
   typedef enum logic [1:0] {
      SRC_REG    = 2'd0,
      SRC_EXTIMM = 2'd1,
      SRC_SHAMT  = 2'd2,
      SRC_LUI    = 2'd3
   } bSrc_t;

   // Held-entry state
   logic              r_heldValid;
   logic [3:0]        r_aluop;
   logic [REG_W-1:0]  r_rs;
   logic [REG_W-1:0]  r_rt;
   logic [WORD_W-1:0] r_rdat1;
   logic [WORD_W-1:0] r_rdat2;
   logic [15:0]       r_imm16;
   logic [4:0]        r_shamt;
   bSrc_t             r_alusrc;
   logic              r_extop;
   logic              r_memwen;
   logic              r_memren;
   logic              r_regwen;
   logic [REG_W-1:0]  r_wsel;

   // Combinational helpers
   logic              w_rsUsed;
   logic              w_rtUsed;
   logic              w_hazard;
   logic              w_inReady;
   logic              w_outValid;
   logic              w_capture;
   logic              w_fire;
   logic [WORD_W-1:0] w_fwdRs;
   logic [WORD_W-1:0] w_fwdRt;
   logic [WORD_W-1:0] w_extImm;
   logic [WORD_W-1:0] w_opA;
   logic [WORD_W-1:0] w_opB;

   // Each instruction class reads only some of its sources. A load-use
   // stall is needed only when the load's destination is one of those.
   // Shifts take their data from rt. Stores need rt as store data whatever
   // B is.
   assign w_rsUsed = (r_alusrc == SRC_REG) || (r_alusrc == SRC_EXTIMM);
   assign w_rtUsed = (r_alusrc == SRC_REG) || (r_alusrc == SRC_SHAMT) || r_memwen;

   // A load in EX/MEM has no data yet, so forwarding cannot cover it.
   // The held entry waits one cycle for the load to move on. Register 0 is
   // hardwired, so a load "to" r0 never creates a dependency.
   assign w_hazard = r_heldValid
                     && bus.exm_regwen
                     && bus.exm_memren
                     && (bus.exm_wsel != '0)
                     && ((w_rsUsed && (bus.exm_wsel == r_rs))
                         || (w_rtUsed && (bus.exm_wsel == r_rt)));

   // Handshake on both sides. The stage can take a new instruction whenever
   // it is empty. It can also take one when the current entry leaves in the
   // same cycle, which keeps back-to-back throughput.
   assign w_outValid = r_heldValid && !w_hazard;
   assign w_inReady  = !r_heldValid || (bus.out_ready && !w_hazard);
   assign w_capture  = bus.in_valid && w_inReady;
   assign w_fire     = w_outValid && bus.out_ready;

   // Forwarding for rs: the younger EX/MEM result wins over MEM/WB. When
   // neither matches, use the value read from the register file at decode
   // time. Index 0 is never forwarded because r0 always reads as its
   // file value.
   always_comb begin
      w_fwdRs = r_rdat1;
      if ((r_rs != '0) && bus.exm_regwen && (bus.exm_wsel == r_rs)) begin
         w_fwdRs = bus.exm_wdat;
      end else if ((r_rs != '0) && bus.mwb_regwen && (bus.mwb_wsel == r_rs)) begin
         w_fwdRs = bus.mwb_wdat;
      end
   end

   // Forwarding for rt uses the same priority. The result feeds the B
   // operand, the A operand of shifts and the store data path.
   always_comb begin
      w_fwdRt = r_rdat2;
      if ((r_rt != '0) && bus.exm_regwen && (bus.exm_wsel == r_rt)) begin
         w_fwdRt = bus.exm_wdat;
      end else if ((r_rt != '0) && bus.mwb_regwen && (bus.mwb_wsel == r_rt)) begin
         w_fwdRt = bus.mwb_wdat;
      end
   end

   // Immediate extension for I-type arithmetic and memory address
   // arithmetic. extop selects sign extension (addi, lw, sw) or zero
   // extension (andi, ori, xori).
   assign w_extImm = r_extop ? {{(WORD_W-16){r_imm16[15]}}, r_imm16}
                             : {{(WORD_W-16){1'b0}}, r_imm16};

   // ALU operand selection. Shifts move rt into A so that the ALU always
   // computes A <op> B. LUI drives A to zero and puts the immediate in the
   // upper half of B, so the ALU only has to pass B through.
   always_comb begin
      w_opA = '0;
      w_opB = '0;
      case (r_alusrc)
         SRC_REG: begin
            w_opA = w_fwdRs;
            w_opB = w_fwdRt;
         end
         SRC_EXTIMM: begin
            w_opA = w_fwdRs;
            w_opB = w_extImm;
         end
         SRC_SHAMT: begin
            w_opA = w_fwdRt;
            w_opB = {{(WORD_W-5){1'b0}}, r_shamt};
         end
         SRC_LUI: begin
            w_opA = '0;
            w_opB = {r_imm16, {(WORD_W-16){1'b0}}};
         end
         default: begin
            w_opA = '0;
            w_opB = '0;
         end
      endcase
   end

   // Occupancy of the single entry. Flush wins over everything, so a
   // redirect squashes the held instruction and also drops whatever decode
   // offers in that cycle. Otherwise a capture refills the entry, even when
   // the old one leaves in the same cycle. A departure with no capture
   // empties it.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_heldValid <= 1'b0;
      end else if (bus.flush) begin
         r_heldValid <= 1'b0;
      end else if (w_capture) begin
         r_heldValid <= 1'b1;
      end else if (w_fire) begin
         r_heldValid <= 1'b0;
      end
   end

   // Decoded fields are loaded only on a real capture. During a stall they
   // stay frozen, and forwarding keeps re-evaluating them against the
   // moving later stages. Every field resets to zero, which also makes the
   // ALU operands and store data read zero while reset is held.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_aluop  <= ALU_SLL;
         r_rs     <= '0;
         r_rt     <= '0;
         r_rdat1  <= '0;
         r_rdat2  <= '0;
         r_imm16  <= '0;
         r_shamt  <= '0;
         r_alusrc <= SRC_REG;
         r_extop  <= 1'b0;
         r_memwen <= 1'b0;
         r_memren <= 1'b0;
         r_regwen <= 1'b0;
         r_wsel   <= '0;
      end else if (w_capture && !bus.flush) begin
         r_aluop  <= bus.in_aluop;
         r_rs     <= bus.in_rs;
         r_rt     <= bus.in_rt;
         r_rdat1  <= bus.in_rdat1;
         r_rdat2  <= bus.in_rdat2;
         r_imm16  <= bus.in_imm16;
         r_shamt  <= bus.in_shamt;
         r_alusrc <= bSrc_t'(bus.in_alusrc);
         r_extop  <= bus.in_extop;
         r_memwen <= bus.in_memwen;
         r_memren <= bus.in_memren;
         r_regwen <= bus.in_regwen;
         r_wsel   <= bus.in_wsel;
      end
   end

`ifdef ID_EX_STALL_CNT_EN
   logic [STALL_CNT_W-1:0] r_stallCnt;

   // Performance counter: counts every cycle in which an instruction sits in
   // the stage but cannot leave, either because of a load-use hazard or
   // because the ALU side is not ready. It saturates rather than wraps, so a
   // long run never shows a misleadingly small number. A flush does not
   // clear it; only reset does.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_stallCnt <= '0;
      end else if (r_heldValid && (w_hazard || !bus.out_ready)
                   && (r_stallCnt != {STALL_CNT_W{1'b1}})) begin
         r_stallCnt <= r_stallCnt + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign stall_cnt = r_stallCnt;
`endif

   // Drive the interface outputs
   assign bus.in_ready   = w_inReady;
   assign bus.out_valid  = w_outValid;
   assign bus.A          = w_opA;
   assign bus.B          = w_opB;
   assign bus.ALUOP      = r_aluop;
   assign bus.out_stdat  = w_fwdRt;
   assign bus.out_memwen = r_memwen;
   assign bus.out_memren = r_memren;
   assign bus.out_regwen = r_regwen;
   assign bus.out_wsel   = r_wsel;

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
//
// Purpose:
//    Self-checking bench for id_ex_stage. A behavioural model follows the
//    held instruction and computes what the ALU-side outputs must be. A
//    compare process checks the DUT against it on every falling edge.
//    Directed sequences also pin hand-computed values for reset, immediate
//    extension, forwarding priority, load-use, shift/LUI, throughput, flush
//    and reset in mid-operation.
//
// Configuration:
//    ID_EX_STALL_CNT_EN - when defined, the stall_cnt output is connected
//    and checked.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_id_ex_stage;

   localparam int WORD_W = 32;
   localparam int REG_W  = 5;

   localparam logic [3:0] ALU_SLL = 4'd0;
   localparam logic [3:0] ALU_ADD = 4'd2;
   localparam logic [3:0] ALU_OR  = 4'd5;

   logic CLK  = 1'b0;
   logic nRST = 1'b1;

`ifdef ID_EX_STALL_CNT_EN
   logic [15:0] stall_cnt;
`endif

   int checks   = 0;
   int failures = 0;
   bit cmpEn    = 1'b0;

   id_ex_stage_if #(.WORD_W(WORD_W), .REG_W(REG_W)) bus ();

   id_ex_stage #(
      .WORD_W(WORD_W),
      .REG_W (REG_W)
   ) dut (
      .CLK      (CLK),
      .nRST     (nRST),
`ifdef ID_EX_STALL_CNT_EN
      .stall_cnt(stall_cnt),
`endif
      .bus      (bus)
   );

   // 100 MHz clock
   always #5 CLK = ~CLK;

   // One instruction as the model remembers it
   typedef struct {
      logic [3:0]  aluop;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [31:0] rdat1;
      logic [31:0] rdat2;
      logic [15:0] imm16;
      logic [4:0]  shamt;
      logic [1:0]  alusrc;
      logic        extop;
      logic        memwen;
      logic        memren;
      logic        regwen;
      logic [4:0]  wsel;
   } entry_t;

   bit     mHeld  = 1'b0;
   entry_t mEntry;
   int     mStall = 0;

   // Value of a source register as the ALU must see it now
   function automatic logic [31:0] srcValue(input logic [4:0] r, input logic [31:0] fileVal);
      if (r == 5'd0) return fileVal;
      if (bus.exm_regwen && bus.exm_wsel == r) return bus.exm_wdat;
      if (bus.mwb_regwen && bus.mwb_wsel == r) return bus.mwb_wdat;
      return fileVal;
   endfunction

   function automatic bit readsRs(input entry_t e);
      return (e.alusrc == 2'd0) || (e.alusrc == 2'd1);
   endfunction

   function automatic bit readsRt(input entry_t e);
      return (e.alusrc == 2'd0) || (e.alusrc == 2'd2) || e.memwen;
   endfunction

   function automatic bit modelHazard();
      bit dep;
      if (!mHeld) return 1'b0;
      if (!(bus.exm_regwen && bus.exm_memren) || bus.exm_wsel == 5'd0) return 1'b0;
      dep = (readsRs(mEntry) && bus.exm_wsel == mEntry.rs)
            || (readsRt(mEntry) && bus.exm_wsel == mEntry.rt);
      return dep;
   endfunction

   function automatic logic [31:0] modelA();
      if (mEntry.alusrc == 2'd3) return 32'd0;
      if (mEntry.alusrc == 2'd2) return srcValue(mEntry.rt, mEntry.rdat2);
      return srcValue(mEntry.rs, mEntry.rdat1);
   endfunction

   function automatic logic [31:0] modelB();
      int unsigned v;
      case (mEntry.alusrc)
         2'd0: v = srcValue(mEntry.rt, mEntry.rdat2);
         2'd1: begin
            v = mEntry.imm16;
            if (mEntry.extop && v >= 32768) v = v + 32'hFFFF0000;
         end
         2'd2: v = mEntry.shamt;
         default: v = mEntry.imm16 * 65536;
      endcase
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic checkBit(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // Model of the stage's occupancy, advanced on every rising edge
   always @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         mHeld  = 1'b0;
         mStall = 0;
      end else begin : mdlStep
         bit hz;
         bit canTake;
         bit leaves;
         hz      = modelHazard();
         canTake = !mHeld || (bus.out_ready && !hz);
         leaves  = mHeld && !hz && bus.out_ready;
         if (mHeld && (hz || !bus.out_ready) && mStall < 65535) mStall++;
         if (bus.flush) begin
            mHeld = 1'b0;
         end else if (bus.in_valid && canTake) begin
            mHeld         = 1'b1;
            mEntry.aluop  = bus.in_aluop;
            mEntry.rs     = bus.in_rs;
            mEntry.rt     = bus.in_rt;
            mEntry.rdat1  = bus.in_rdat1;
            mEntry.rdat2  = bus.in_rdat2;
            mEntry.imm16  = bus.in_imm16;
            mEntry.shamt  = bus.in_shamt;
            mEntry.alusrc = bus.in_alusrc;
            mEntry.extop  = bus.in_extop;
            mEntry.memwen = bus.in_memwen;
            mEntry.memren = bus.in_memren;
            mEntry.regwen = bus.in_regwen;
            mEntry.wsel   = bus.in_wsel;
         end else if (leaves) begin
            mHeld = 1'b0;
         end
      end
   end

   // Compare the DUT with the model on every falling edge
   always @(negedge CLK) begin
      if (cmpEn) begin
         if (!nRST) begin
            checkBit("rstOutValid", bus.out_valid, 1'b0);
            checkBit("rstInReady", bus.in_ready, 1'b1);
            checkOutput("rstA", bus.A, 32'd0);
            checkOutput("rstB", bus.B, 32'd0);
            checkOutput("rstStdat", bus.out_stdat, 32'd0);
         end else begin : cmpStep
            bit hz;
            hz = modelHazard();
            checkBit("mdlOutValid", bus.out_valid, mHeld && !hz);
            checkBit("mdlInReady", bus.in_ready, !mHeld || (bus.out_ready && !hz));
            if (mHeld) begin
               checkOutput("mdlA", bus.A, modelA());
               checkOutput("mdlB", bus.B, modelB());
               checkOutput("mdlAluop", 32'(bus.ALUOP), 32'(mEntry.aluop));
               checkOutput("mdlStdat", bus.out_stdat, srcValue(mEntry.rt, mEntry.rdat2));
               checkBit("mdlMemwen", bus.out_memwen, mEntry.memwen);
               checkBit("mdlMemren", bus.out_memren, mEntry.memren);
               checkBit("mdlRegwen", bus.out_regwen, mEntry.regwen);
               checkOutput("mdlWsel", 32'(bus.out_wsel), 32'(mEntry.wsel));
            end
         end
`ifdef ID_EX_STALL_CNT_EN
         checkOutput("mdlStall", 32'(stall_cnt), 32'(mStall));
`endif
      end
   end

   // Safety net so the run always ends
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic clearInputs();
      bus.flush      = 1'b0;
      bus.in_valid   = 1'b0;
      bus.in_aluop   = 4'd0;
      bus.in_rs      = 5'd0;
      bus.in_rt      = 5'd0;
      bus.in_rdat1   = 32'd0;
      bus.in_rdat2   = 32'd0;
      bus.in_imm16   = 16'd0;
      bus.in_shamt   = 5'd0;
      bus.in_alusrc  = 2'd0;
      bus.in_extop   = 1'b0;
      bus.in_memwen  = 1'b0;
      bus.in_memren  = 1'b0;
      bus.in_regwen  = 1'b0;
      bus.in_wsel    = 5'd0;
      bus.exm_regwen = 1'b0;
      bus.exm_memren = 1'b0;
      bus.exm_wsel   = 5'd0;
      bus.exm_wdat   = 32'd0;
      bus.mwb_regwen = 1'b0;
      bus.mwb_wsel   = 5'd0;
      bus.mwb_wdat   = 32'd0;
   endtask

   // Present one decoded instruction to the stage
   task automatic applyStimulus(
      input logic [3:0]  aluop,
      input logic [4:0]  rs,
      input logic [4:0]  rt,
      input logic [31:0] rdat1,
      input logic [31:0] rdat2,
      input logic [15:0] imm16,
      input logic [4:0]  shamt,
      input logic [1:0]  alusrc,
      input logic        extop,
      input logic        memwen,
      input logic        regwen,
      input logic [4:0]  wsel
   );
      bus.in_valid  = 1'b1;
      bus.in_aluop  = aluop;
      bus.in_rs     = rs;
      bus.in_rt     = rt;
      bus.in_rdat1  = rdat1;
      bus.in_rdat2  = rdat2;
      bus.in_imm16  = imm16;
      bus.in_shamt  = shamt;
      bus.in_alusrc = alusrc;
      bus.in_extop  = extop;
      bus.in_memwen = memwen;
      bus.in_memren = 1'b0;
      bus.in_regwen = regwen;
      bus.in_wsel   = wsel;
   endtask

   initial begin : stimulus
      int validRun;
      int stallBefore;

      clearInputs();
      bus.out_ready = 1'b1;
      cmpEn = 1'b1;
      #1 nRST = 1'b0;

      // Reset state
      @(negedge CLK);
      checkBit("resetOutValid", bus.out_valid, 1'b0);
      checkBit("resetInReady", bus.in_ready, 1'b1);
      checkOutput("resetA", bus.A, 32'd0);
      checkOutput("resetAluop", 32'(bus.ALUOP), 32'(ALU_SLL));
      @(posedge CLK);
      #1 nRST = 1'b1;

      // ADDI with sign-extended and zero-extended immediate
      applyStimulus(ALU_ADD, 5'd1, 5'd2, 32'd5, 32'd0, 16'hFFFE, 5'd0, 2'd1, 1'b1, 1'b0, 1'b1, 5'd2);
      tick();
      bus.in_valid = 1'b0;
      @(negedge CLK);
      checkBit("addiValid", bus.out_valid, 1'b1);
      checkOutput("addiA", bus.A, 32'd5);
      checkOutput("addiBsext", bus.B, 32'hFFFFFFFE);
      checkOutput("addiAluop", 32'(bus.ALUOP), 32'(ALU_ADD));
      applyStimulus(ALU_ADD, 5'd1, 5'd2, 32'd5, 32'd0, 16'hFFFE, 5'd0, 2'd1, 1'b0, 1'b0, 1'b1, 5'd2);
      tick();
      bus.in_valid = 1'b0;
      @(negedge CLK);
      checkBit("addizValid", bus.out_valid, 1'b1);
      checkOutput("addiBzext", bus.B, 32'h0000FFFE);
      tick();
      @(negedge CLK);
      checkBit("drainValid", bus.out_valid, 1'b0);

      // Forwarding priority while the entry is held
      bus.out_ready = 1'b0;
      applyStimulus(ALU_ADD, 5'd3, 5'd3, 32'h11, 32'h22, 16'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b1, 5'd7);
      bus.exm_regwen = 1'b1;
      bus.exm_wsel   = 5'd3;
      bus.exm_wdat   = 32'hAAAA;
      bus.mwb_regwen = 1'b1;
      bus.mwb_wsel   = 5'd3;
      bus.mwb_wdat   = 32'hBBBB;
      tick();
      bus.in_valid = 1'b0;
      @(negedge CLK);
      checkOutput("fwdExmA", bus.A, 32'hAAAA);
      checkOutput("fwdExmB", bus.B, 32'hAAAA);
      checkOutput("fwdExmStdat", bus.out_stdat, 32'hAAAA);
      checkBit("heldInReady", bus.in_ready, 1'b0);
      bus.exm_regwen = 1'b0;
      tick();
      @(negedge CLK);
      checkOutput("fwdMwbA", bus.A, 32'hBBBB);
      checkOutput("fwdMwbB", bus.B, 32'hBBBB);
      bus.mwb_regwen = 1'b0;
      tick();
      @(negedge CLK);
      checkOutput("noFwdA", bus.A, 32'h11);
      checkOutput("noFwdB", bus.B, 32'h22);
      bus.out_ready = 1'b1;
      applyStimulus(ALU_ADD, 5'd0, 5'd0, 32'd0, 32'd0, 16'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b1, 5'd8);
      bus.exm_regwen = 1'b1;
      bus.exm_wsel   = 5'd0;
      bus.mwb_regwen = 1'b1;
      bus.mwb_wsel   = 5'd0;
      tick();
      bus.in_valid = 1'b0;
      @(negedge CLK);
      checkOutput("r0NoFwdA", bus.A, 32'd0);
      checkOutput("r0NoFwdB", bus.B, 32'd0);
      tick();
      clearInputs();

      // Load-use hazard for one cycle
      applyStimulus(ALU_ADD, 5'd4, 5'd5, 32'h44, 32'h55, 16'h0010, 5'd0, 2'd1, 1'b1, 1'b0, 1'b1, 5'd9);
      tick();
      bus.in_valid   = 1'b0;
      bus.exm_regwen = 1'b1;
      bus.exm_memren = 1'b1;
      bus.exm_wsel   = 5'd4;
      bus.exm_wdat   = 32'hDEADBEEF;
      @(negedge CLK);
      checkBit("luOutValid", bus.out_valid, 1'b0);
      checkBit("luInReady", bus.in_ready, 1'b0);
      stallBefore = mStall;
      tick();
      bus.exm_memren = 1'b0;
      @(negedge CLK);
      checkBit("luResolvedValid", bus.out_valid, 1'b1);
      checkOutput("luResolvedA", bus.A, 32'hDEADBEEF);
      checkOutput("luResolvedB", bus.B, 32'h00000010);
`ifdef ID_EX_STALL_CNT_EN
      checkOutput("luStallInc", 32'(stall_cnt), 32'(stallBefore + 1));
`else
      checkOutput("luModelStallInc", 32'(mStall), 32'(stallBefore + 1));
`endif
      tick();
      clearInputs();

      // Shift and LUI operand building
      applyStimulus(ALU_SLL, 5'd7, 5'd6, 32'h99, 32'h1, 16'd0, 5'd4, 2'd2, 1'b0, 1'b0, 1'b1, 5'd10);
      tick();
      bus.in_valid = 1'b0;
      @(negedge CLK);
      checkOutput("shiftA", bus.A, 32'd1);
      checkOutput("shiftB", bus.B, 32'd4);
      applyStimulus(ALU_OR, 5'd0, 5'd11, 32'h0, 32'h0, 16'h1234, 5'd0, 2'd3, 1'b0, 1'b0, 1'b1, 5'd11);
      tick();
      bus.in_valid = 1'b0;
      @(negedge CLK);
      checkOutput("luiA", bus.A, 32'd0);
      checkOutput("luiB", bus.B, 32'h12340000);
      tick();

      // Back-to-back throughput of four instructions
      validRun = 0;
      for (int k = 1; k <= 4; k++) begin
         applyStimulus(ALU_ADD, 5'(k), 5'(k), 32'(k * 16), 32'(k), 16'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b1, 5'(k));
         tick();
         @(negedge CLK);
         if (bus.out_valid) validRun++;
         checkOutput("tputWsel", 32'(bus.out_wsel), 32'(k));
         checkOutput("tputA", bus.A, 32'(k * 16));
      end
      bus.in_valid = 1'b0;
      tick();
      @(negedge CLK);
      checkOutput("tputRun", 32'(validRun), 32'd4);
      checkBit("tputDrained", bus.out_valid, 1'b0);

      // Flush of a held entry, then flush racing a capture
      bus.out_ready = 1'b0;
      applyStimulus(ALU_ADD, 5'd12, 5'd13, 32'h77, 32'h88, 16'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b1, 5'd9);
      tick();
      bus.in_valid = 1'b0;
      @(negedge CLK);
      checkBit("preFlushValid", bus.out_valid, 1'b1);
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      @(negedge CLK);
      checkBit("flushOutValid", bus.out_valid, 1'b0);
      checkBit("flushInReady", bus.in_ready, 1'b1);
      bus.out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         @(negedge CLK);
         checkBit("flushGone", bus.out_valid, 1'b0);
      end
      applyStimulus(ALU_ADD, 5'd14, 5'd15, 32'h1, 32'h2, 16'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b1, 5'd10);
      bus.flush = 1'b1;
      tick();
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      @(negedge CLK);
      checkBit("flushBeatsCapture", bus.out_valid, 1'b0);

      // Reset while an entry is held
      bus.out_ready = 1'b0;
      applyStimulus(ALU_ADD, 5'd8, 5'd8, 32'h5555, 32'h6666, 16'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b1, 5'd11);
      tick();
      bus.in_valid = 1'b0;
      @(negedge CLK);
      checkOutput("preRstA", bus.A, 32'h5555);
      #2 nRST = 1'b0;
      #1;
      checkBit("midRstOutValid", bus.out_valid, 1'b0);
      checkBit("midRstInReady", bus.in_ready, 1'b1);
      checkOutput("midRstA", bus.A, 32'd0);
      checkOutput("midRstB", bus.B, 32'd0);
`ifdef ID_EX_STALL_CNT_EN
      checkOutput("midRstStall", 32'(stall_cnt), 32'd0);
`endif
      @(posedge CLK);
      #1 nRST = 1'b1;
      tick();
      @(negedge CLK);
      checkBit("postRstValid", bus.out_valid, 1'b0);

      cmpEn = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline register that sits directly upstream of the ALU.
- Captures decoded operands from the decode stage.
- Applies EX/MEM and MEM/WB forwarding.
- Builds the ALU A/B operands (register, extended immediate, shamt, LUI) and drives A, B and ALUOP.
- Detects load-use hazards and holds with a valid/ready handshake.

Parameters:
WORD_W, 32, datapath width
REG_W, 5, register index width
STALL_CNT_W, 16, stall counter width (optional feature only)

Ports:
CLK  in  1  clock
nRST  in  1  asynchronous active-low reset
flush  in  1  squash held entry (branch/jump redirect)
in_valid  in  1  decode has an instruction
in_ready  out  1  stage can accept
in_aluop  in  4  aluop_t from cpu_types_pkg
in_rs, in_rt  in  REG_W  source indices
in_rdat1, in_rdat2  in  WORD_W  register file read data
in_imm16  in  16  immediate
in_shamt  in  5  shift amount
in_alusrc  in  2  B select: 0 reg, 1 ext imm, 2 shamt, 3 lui
in_extop  in  1  1 sign-extend imm, 0 zero-extend
in_memwen  in  1  store instruction
in_memren  in  1  load instruction
in_regwen  in  1  writes a register
in_wsel  in  REG_W  destination index
exm_regwen, exm_memren  in  1  EX/MEM writes / is a load
exm_wsel  in  REG_W  EX/MEM destination
exm_wdat  in  WORD_W  EX/MEM result
mwb_regwen  in  1  MEM/WB writes
mwb_wsel  in  REG_W  MEM/WB destination
mwb_wdat  in  WORD_W  MEM/WB result
out_valid  out  1  A/B/ALUOP valid for the ALU
out_ready  in  1  downstream accepts
A, B  out  WORD_W  ALU operands
ALUOP  out  4  ALU opcode
out_stdat  out  WORD_W  forwarded rt (store data)
out_memwen, out_memren, out_regwen  out  1  registered controls
out_wsel  out  REG_W  registered destination

Behaviour:
- Reset (async, nRST low):
  - Held-valid bit 0, so out_valid is 0.
  - All registered fields 0; ALUOP resets to ALU_SLL (encoding 0).
  - A, B and out_stdat read 0 while reset is held.
- Forwarding (combinational, EX/MEM priority over MEM/WB):
  - fwd(r) = exm_wdat if exm_regwen && exm_wsel==r && r!=0.
  - Otherwise mwb_wdat if mwb_regwen && mwb_wsel==r && r!=0.
  - Otherwise the registered rdat.
  - Register 0 is never forwarded.
- Operand use:
  - rs is used when alusrc ∈ {0,1}.
  - rt is used when alusrc ∈ {0,2} or memwen.
- A/B select:
  - alusrc 0: A=fwd(rs), B=fwd(rt).
  - alusrc 1: A=fwd(rs), B=imm16 sign- or zero-extended per extop.
  - alusrc 2: A=fwd(rt), B={27'b0,shamt}.
  - alusrc 3: A=0, B={imm16,16'h0}.
  - out_stdat = fwd(rt) always.
- Load-use hazard: held-valid && exm_regwen && exm_memren && exm_wsel!=0 && exm_wsel matches a used source.
- Handshake:
  - out_valid = held-valid && !hazard.
  - in_ready = !held-valid || (out_ready && !hazard).
  - Capture on in_valid && in_ready; held-valid becomes 1.
  - If out_valid && out_ready and no capture, held-valid becomes 0.
  - Simultaneous fire and capture gives back-to-back throughput of 1 instruction per cycle.
- Hazard: entry held and all registers stable; out_valid 0; in_ready 0; resolves as soon as EX/MEM advances.
- flush: has priority over capture and fire; the next cycle has held-valid 0 and nothing captured. Registered data fields may keep their old values.
- Reset mid-operation drops the held entry immediately, with no partial output.

Optional Feature:
Macro ID_EX_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt [STALL_CNT_W].
  - Increments every cycle with held-valid && (hazard || !out_ready); saturates at all-ones.
  - Resets to 0 on nRST.
  - Not affected by flush.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Reset: nRST low mid-transfer → out_valid=0, A=B=0, in_ready=1 immediately, stall_cnt=0.
- ADDI with alusrc=1, extop=1, imm16=16'hFFFE, rdat1=5, no forwards → next cycle out_valid=1, A=5, B=32'hFFFFFFFE, ALUOP=ALU_ADD. Repeat with extop=0 → B=32'h0000FFFE.
- Forwarding priority: rs=rt=3; exm_wsel=3 with 32'hAAAA, mwb_wsel=3 with 32'hBBBB → A=B=32'hAAAA. Drop exm_regwen → 32'hBBBB. Set rs=rt=0 → A=B=rdat values (0), with no forwarding.
- Load-use: held rs=4, exm_memren=1, exm_wsel=4 for 1 cycle → out_valid=0 and in_ready=0 for that cycle; next cycle out_valid=1, A=exm_wdat; stall_cnt +1.
- Shift/LUI: alusrc=2, rt data 32'h1, shamt=4 → A=1, B=4. alusrc=3, imm16=16'h1234 → A=0, B=32'h12340000.
- Throughput and flush: in_valid and out_ready held high for 4 instructions → 4 consecutive out_valid cycles. Assert flush while out_ready=0 → next cycle out_valid=0, and the flushed instruction never appears.
